// File: rtl/starforc_gfxrom_arb_pkg.sv
// starforc_gfx_pkg: shared types and constants for the Star Force graphics-ROM
// fetch arbiter.
//   gfx_state_e  arbiter FSM states
//   *_PLANES     plane bytes fetched per burst (sprite 6, char 3)
//   *_STRIDE     byte distance between consecutive plane ROMs in mem_addr space
package starforc_gfx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    REQ,
    COMMIT,
    WRITE
  } gfx_state_e;

  localparam int          SPR_PLANES = 6;
  localparam int          CHR_PLANES = 3;
  localparam logic [15:0] SPR_STRIDE = 16'h2000;
  localparam logic [15:0] CHR_STRIDE = 16'h1000;

endpackage

// File: rtl/starforc_gfxrom_arb_if.sv
// starforc_gfxrom_arb_if: byte-wide graphics ROM port shared by the arbiter.
//   mem_addr   byte address            (arbiter -> memory)
//   mem_rd     read request, held until mem_ack
//   mem_ack    single-cycle acknowledge (memory -> arbiter)
//   mem_data   read data, valid with mem_ack
//   mem_wr / mem_wdata  download write path, present only with
//   STARFORC_GFXARB_DL_EN defined
interface starforc_gfxrom_arb_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;
`ifdef STARFORC_GFXARB_DL_EN
  logic        mem_wr;
  logic [7:0]  mem_wdata;

  modport master (output mem_addr, mem_rd, mem_wr, mem_wdata,
                  input  mem_ack, mem_data);
  modport slave  (input  mem_addr, mem_rd, mem_wr, mem_wdata,
                  output mem_ack, mem_data);
`else
  modport master (output mem_addr, mem_rd,
                  input  mem_ack, mem_data);
  modport slave  (input  mem_addr, mem_rd,
                  output mem_ack, mem_data);
`endif
endinterface

// File: rtl/starforc_gfxrom_arb_addr_chg.sv
// starforc_addr_chg: per-requester change detector.
//   clk, reset   clock, synchronous active-high reset
//   addr_in      live requester address
//   load         FSM GRANT strobe: remember addr_in as the fetched address
//   commit       FSM COMMIT strobe: burst for last_addr is now on the outputs
//   force_pend   force a re-fetch even if the address is unchanged
//   last_addr    address of the burst in flight / last committed
//   pending      a fetch is needed
//   valid        committed outputs belong to the current addr_in
module starforc_addr_chg
  #(parameter int W = 12)
  (input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] addr_in,
   input  logic         load,
   input  logic         commit,
   input  logic         force_pend,
   output logic [W-1:0] last_addr,
   output logic         pending,
   output logic         valid);

  logic [W-1:0] last_q, last_d;
  logic         force_q, force_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         match;

  always_comb begin
    last_d  = last_q;
    force_d = force_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (load) begin
      last_d  = addr_in;
      force_d = 1'b0;
      busy_d  = 1'b1;
    end
    if (commit) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (force_pend) force_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= '0;
      force_q <= 1'b1;   // nothing fetched yet: both requesters start pending
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      force_q <= force_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign match     = (addr_in == last_q);
  assign last_addr = last_q;
  assign pending   = force_q || !match;
  assign valid     = match && !force_q && !busy_q && done_q;

endmodule

// File: rtl/starforc_gfxrom_arb.sv
// starforc_gfxrom_arb: shares one byte-wide ROM port between the sprite tile
// fetch (6 plane bytes, rom9..rom14) and the char fetch (3 plane bytes,
// rom6..rom8). Each burst is gathered in shadow registers and copied to the
// outputs in a single cycle so the serializers never see a mixed word set.
//   clk48m, reset        clock, synchronous active-high reset
//   spr_addr, chr_addr   requester addresses
//   mem                  ROM port (starforc_gfxrom_arb_if.master)
//   rom6_o..rom14_o      committed plane bytes
//   spr_valid, chr_valid committed data matches the current address
//   dl_wr/dl_addr/dl_data/dl_ack  ROM download port, only with
//   STARFORC_GFXARB_DL_EN defined
//
// state  | meaning
// IDLE   | pick a requester (download first, then alternate on contention)
// GRANT  | latch the granted address, plane index = 0
// REQ    | read one plane byte per ack into the shadow registers
// COMMIT | copy shadow bytes to the outputs
// WRITE  | download write held until mem_ack
module starforc_gfxrom_arb
  import starforc_gfx_pkg::*;
  #(parameter logic [15:0] SPR_BASE = 16'h4000,
    parameter logic [15:0] CHR_BASE = 16'h0000)
  (input  logic        clk48m,
   input  logic        reset,
   input  logic [12:0] spr_addr,
   input  logic [11:0] chr_addr,
   starforc_gfxrom_arb_if.master mem,
   output logic [7:0]  rom6_o,
   output logic [7:0]  rom7_o,
   output logic [7:0]  rom8_o,
   output logic [7:0]  rom9_o,
   output logic [7:0]  rom10_o,
   output logic [7:0]  rom11_o,
   output logic [7:0]  rom12_o,
   output logic [7:0]  rom13_o,
   output logic [7:0]  rom14_o,
   output logic        spr_valid,
   output logic        chr_valid
`ifdef STARFORC_GFXARB_DL_EN
  ,input  logic        dl_wr,
   input  logic [15:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_ack
`endif
  );

  gfx_state_e        state_q, state_d;
  logic              sel_q, sel_d;              // 1 = sprite burst
  logic              last_grant_q, last_grant_d; // 1 = sprite served last
  logic [2:0]        plane_q, plane_d;
  logic [5:0][7:0]   spr_sh_q, spr_sh_d, spr_out_q, spr_out_d;
  logic [2:0][7:0]   chr_sh_q, chr_sh_d, chr_out_q, chr_out_d;

  logic              spr_load, chr_load, spr_commit, chr_commit, set_pend;
  logic              spr_pend, chr_pend, last_plane;
  logic [12:0]       spr_last;
  logic [11:0]       chr_last;
  logic [15:0]       spr_mem_addr, chr_mem_addr, mem_addr_c;
  logic              mem_rd_c;

  starforc_addr_chg #(.W(13)) u_spr_chg (
    .clk(clk48m), .reset(reset), .addr_in(spr_addr), .load(spr_load),
    .commit(spr_commit), .force_pend(set_pend), .last_addr(spr_last),
    .pending(spr_pend), .valid(spr_valid));

  starforc_addr_chg #(.W(12)) u_chr_chg (
    .clk(clk48m), .reset(reset), .addr_in(chr_addr), .load(chr_load),
    .commit(chr_commit), .force_pend(set_pend), .last_addr(chr_last),
    .pending(chr_pend), .valid(chr_valid));

  // Addresses come from the latched copy so a mid-burst input change cannot
  // tear the plane set.
  assign spr_mem_addr = SPR_BASE + 16'(plane_q) * SPR_STRIDE + {3'b0, spr_last};
  assign chr_mem_addr = CHR_BASE + 16'(plane_q) * CHR_STRIDE + {4'b0, chr_last};
  assign last_plane   = sel_q ? (plane_q == 3'(SPR_PLANES - 1))
                              : (plane_q == 3'(CHR_PLANES - 1));

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    plane_d      = plane_q;
    spr_sh_d     = spr_sh_q;
    chr_sh_d     = chr_sh_q;
    spr_out_d    = spr_out_q;
    chr_out_d    = chr_out_q;
    spr_load     = 1'b0;
    chr_load     = 1'b0;
    spr_commit   = 1'b0;
    chr_commit   = 1'b0;
    set_pend     = 1'b0;
    mem_rd_c     = 1'b0;
    mem_addr_c   = 16'h0000;
`ifdef STARFORC_GFXARB_DL_EN
    mem.mem_wr    = 1'b0;
    mem.mem_wdata = 8'h00;
    dl_ack        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef STARFORC_GFXARB_DL_EN
        if (dl_wr) state_d = WRITE;
        else
`endif
        if (chr_pend || spr_pend) begin
          state_d = GRANT;
          if (chr_pend && spr_pend) sel_d = ~last_grant_q;
          else                      sel_d = spr_pend;
        end
      end
      GRANT: begin
        spr_load     = sel_q;
        chr_load     = !sel_q;
        last_grant_d = sel_q;
        plane_d      = 3'd0;
        state_d      = REQ;
      end
      REQ: begin
        mem_rd_c   = 1'b1;
        mem_addr_c = sel_q ? spr_mem_addr : chr_mem_addr;
        if (mem.mem_ack) begin
          if (sel_q) spr_sh_d[plane_q]      = mem.mem_data;
          else       chr_sh_d[plane_q[1:0]] = mem.mem_data;
          if (last_plane) state_d = COMMIT;
          else            plane_d = plane_q + 3'd1;
        end
      end
      COMMIT: begin
        if (sel_q) begin
          spr_out_d  = spr_sh_q;
          spr_commit = 1'b1;
        end else begin
          chr_out_d  = chr_sh_q;
          chr_commit = 1'b1;
        end
        state_d = IDLE;
      end
`ifdef STARFORC_GFXARB_DL_EN
      WRITE: begin
        mem.mem_wr    = 1'b1;
        mem.mem_wdata = dl_data;
        mem_addr_c    = dl_addr;
        if (mem.mem_ack) begin
          dl_ack   = 1'b1;
          set_pend = 1'b1;   // ROM contents may have changed under both
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk48m) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;   // char wins the first contention
      plane_q      <= 3'd0;
      spr_sh_q     <= '0;
      chr_sh_q     <= '0;
      spr_out_q    <= '0;
      chr_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      plane_q      <= plane_d;
      spr_sh_q     <= spr_sh_d;
      chr_sh_q     <= chr_sh_d;
      spr_out_q    <= spr_out_d;
      chr_out_q    <= chr_out_d;
    end
  end

  assign mem.mem_rd   = mem_rd_c;
  assign mem.mem_addr = mem_addr_c;

  assign rom6_o  = chr_out_q[0];
  assign rom7_o  = chr_out_q[1];
  assign rom8_o  = chr_out_q[2];
  assign rom9_o  = spr_out_q[0];
  assign rom10_o = spr_out_q[1];
  assign rom11_o = spr_out_q[2];
  assign rom12_o = spr_out_q[3];
  assign rom13_o = spr_out_q[4];
  assign rom14_o = spr_out_q[5];

endmodule

// File: tb/tb_starforc_gfxrom_arb.sv
// Testbench for starforc_gfxrom_arb. ROM model byte at address a is
// {a[15:12], a[3:0]} ^ 8'h5A, acked one cycle after the address appears.
// The download test is compiled only with STARFORC_GFXARB_DL_EN defined.
module tb_starforc_gfxrom_arb;
  import starforc_gfx_pkg::*;

  logic        clk48m = 1'b0;
  logic        reset;
  logic [12:0] spr_addr;
  logic [11:0] chr_addr;
  logic [7:0]  rom6_o, rom7_o, rom8_o, rom9_o, rom10_o, rom11_o, rom12_o,
               rom13_o, rom14_o;
  logic        spr_valid, chr_valid;
  logic        ack_q;
  logic [7:0]  rdata_q;
  int          n_tests = 0;
  int          n_fail  = 0;

  starforc_gfxrom_arb_if mif ();

`ifdef STARFORC_GFXARB_DL_EN
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_ack;
  logic        wr_valid_q;
  logic [15:0] wr_addr_q;
  logic [7:0]  wr_data_q;
`endif

  starforc_gfxrom_arb dut (
    .clk48m(clk48m), .reset(reset), .spr_addr(spr_addr), .chr_addr(chr_addr),
    .mem(mif.master),
    .rom6_o(rom6_o), .rom7_o(rom7_o), .rom8_o(rom8_o), .rom9_o(rom9_o),
    .rom10_o(rom10_o), .rom11_o(rom11_o), .rom12_o(rom12_o),
    .rom13_o(rom13_o), .rom14_o(rom14_o),
    .spr_valid(spr_valid), .chr_valid(chr_valid)
`ifdef STARFORC_GFXARB_DL_EN
   ,.dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack)
`endif
  );

  always #5 clk48m = ~clk48m;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
`ifdef STARFORC_GFXARB_DL_EN
    if (wr_valid_q && a == wr_addr_q) return wr_data_q;
`endif
    return {a[15:12], a[3:0]} ^ 8'h5A;
  endfunction

  always @(posedge clk48m) begin
    if (reset) begin
      ack_q <= 1'b0;
`ifdef STARFORC_GFXARB_DL_EN
      wr_valid_q <= 1'b0;
`endif
    end else begin
`ifdef STARFORC_GFXARB_DL_EN
      ack_q <= (mif.mem_rd || mif.mem_wr) && !ack_q;
      if (mif.mem_wr && ack_q) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= mif.mem_addr;
        wr_data_q  <= mif.mem_wdata;
      end
`else
      ack_q <= mif.mem_rd && !ack_q;
`endif
      rdata_q <= rom_byte(mif.mem_addr);
    end
  end

  assign mif.mem_ack  = ack_q;
  assign mif.mem_data = rdata_q;

  task automatic tick(input int n);
    repeat (n) @(posedge clk48m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for mem_rd to reach lvl; the final check flags a timeout.
  task automatic wait_rd(input string tag, input logic lvl);
    int n;
    n = 0;
    while (mif.mem_rd !== lvl && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, 16'(mif.mem_rd), 16'(lvl));
  endtask

  initial begin
    reset    = 1'b1;
    spr_addr = 13'h0005;
    chr_addr = 12'h010;
`ifdef STARFORC_GFXARB_DL_EN
    dl_wr   = 1'b0;
    dl_addr = 16'h0000;
    dl_data = 8'h00;
`endif
    tick(3);
    chk("rst_state", 16'(dut.state_q), 16'(IDLE));
    chk("rst_mem_rd", 16'(mif.mem_rd), 16'h0);
    chk("rst_mem_addr", mif.mem_addr, 16'h0000);
    chk("rst_rom6", 16'(rom6_o), 16'h00);
    chk("rst_rom14", 16'(rom14_o), 16'h00);
    chk("rst_spr_valid", 16'(spr_valid), 16'h0);
    chk("rst_chr_valid", 16'(chr_valid), 16'h0);

    // First fetch: char then sprite, minimum latency.
    reset = 1'b0;
    tick(1);
    chk("grant_state", 16'(dut.state_q), 16'(GRANT));
    chk("grant_no_rd", 16'(mif.mem_rd), 16'h0);
    tick(1);
    chk("chr_rd_rise", 16'(mif.mem_rd), 16'h1);
    chk("chr_a0", mif.mem_addr, 16'h0010);
    tick(2);
    chk("chr_a1", mif.mem_addr, 16'h1010);
    tick(2);
    chk("chr_a2", mif.mem_addr, 16'h2010);
    tick(2);
    chk("chr_commit_rd", 16'(mif.mem_rd), 16'h0);
    chk("chr_pre_valid", 16'(chr_valid), 16'h0);
    chk("chr_pre_rom6", 16'(rom6_o), 16'h00);
    tick(1);
    chk("chr_valid", 16'(chr_valid), 16'h1);
    chk("rom6", 16'(rom6_o), 16'h5A);
    chk("rom7", 16'(rom7_o), 16'h4A);
    chk("rom8", 16'(rom8_o), 16'h7A);
    chk("spr_not_valid", 16'(spr_valid), 16'h0);
    tick(2);
    chk("spr_a0", mif.mem_addr, 16'h4005);
    tick(2);
    chk("spr_a1", mif.mem_addr, 16'h6005);
    tick(8);
    chk("spr_a5", mif.mem_addr, 16'hE005);
    tick(2);
    chk("spr_pre_valid", 16'(spr_valid), 16'h0);
    tick(1);
    chk("spr_valid", 16'(spr_valid), 16'h1);
    chk("rom9", 16'(rom9_o), 16'h1F);
    chk("rom10", 16'(rom10_o), 16'h3F);
    chk("rom11", 16'(rom11_o), 16'hDF);
    chk("rom12", 16'(rom12_o), 16'hFF);
    chk("rom13", 16'(rom13_o), 16'h9F);
    chk("rom14", 16'(rom14_o), 16'hBF);
    chk("chr_still_valid", 16'(chr_valid), 16'h1);

    // Char address changes during sprite plane 2.
    spr_addr = 13'h0001;
    tick(2);
    chk("t2_spr_a0", mif.mem_addr, 16'h4001);
    tick(4);
    chk("t2_spr_a2", mif.mem_addr, 16'h8001);
    chr_addr = 12'h011;
    #1;
    chk("t2_chr_drop", 16'(chr_valid), 16'h0);
    tick(8);
    chk("t2_spr_commit_rd", 16'(mif.mem_rd), 16'h0);
    chk("t2_chr_invalid", 16'(chr_valid), 16'h0);
    tick(1);
    chk("t2_spr_valid", 16'(spr_valid), 16'h1);
    chk("t2_rom9", 16'(rom9_o), 16'h1B);
    chk("t2_rom14", 16'(rom14_o), 16'hBB);
    chk("t2_chr_wait", 16'(chr_valid), 16'h0);
    tick(2);
    chk("t2_chr_a0", mif.mem_addr, 16'h0011);
    tick(7);
    chk("t2_chr_valid", 16'(chr_valid), 16'h1);
    chk("t2_rom6", 16'(rom6_o), 16'h5B);
    chk("t2_rom7", 16'(rom7_o), 16'h4B);
    chk("t2_rom8", 16'(rom8_o), 16'h7B);

    // Sprite address changes during its own plane 4.
    spr_addr = 13'h0002;
    tick(2);
    chk("t3_a0", mif.mem_addr, 16'h4002);
    tick(8);
    chk("t3_a4", mif.mem_addr, 16'hC002);
    spr_addr = 13'h0003;
    #1;
    chk("t3_drop", 16'(spr_valid), 16'h0);
    tick(5);
    chk("t3_old_rom9", 16'(rom9_o), 16'h18);
    chk("t3_old_rom13", 16'(rom13_o), 16'h98);
    chk("t3_still_invalid", 16'(spr_valid), 16'h0);
    tick(2);
    chk("t3_new_a0", mif.mem_addr, 16'h4003);
    tick(13);
    chk("t3_valid", 16'(spr_valid), 16'h1);
    chk("t3_rom9", 16'(rom9_o), 16'h19);
    chk("t3_rom14", 16'(rom14_o), 16'hB9);

    // Both requesters kept pending: grants alternate char/sprite.
    spr_addr = 13'h0004;
    chr_addr = 12'h012;
    for (int i = 0; i < 4; i++) begin
      wait_rd("t4_rd_rise", 1'b1);
      chk("t4_alt", 16'(mif.mem_addr >= 16'h4000), 16'(i % 2));
      wait_rd("t4_rd_fall", 1'b0);
      spr_addr = spr_addr + 13'h1;
      chr_addr = chr_addr + 12'h1;
    end
    tick(80);
    chk("t4_spr_valid", 16'(spr_valid), 16'h1);
    chk("t4_chr_valid", 16'(chr_valid), 16'h1);

    // Reset during sprite plane 3.
    spr_addr = 13'h0000;
    wait_rd("t5_rd_rise", 1'b1);
    chk("t5_a0", mif.mem_addr, 16'h4000);
    tick(6);
    chk("t5_a3", mif.mem_addr, 16'hA000);
    reset = 1'b1;
    tick(1);
    chk("t5_rd", 16'(mif.mem_rd), 16'h0);
    chk("t5_addr", mif.mem_addr, 16'h0000);
    chk("t5_rom9", 16'(rom9_o), 16'h00);
    chk("t5_rom6", 16'(rom6_o), 16'h00);
    chk("t5_spr_valid", 16'(spr_valid), 16'h0);
    chk("t5_chr_valid", 16'(chr_valid), 16'h0);
    reset = 1'b0;
    wait_rd("t5_refetch", 1'b1);
    chk("t5_chr_first", mif.mem_addr, {4'h0, chr_addr});
    tick(40);
    chk("t5_chr_valid_after", 16'(chr_valid), 16'h1);
    chk("t5_spr_valid_after", 16'(spr_valid), 16'h1);
    chk("t5_rom9_after", 16'(rom9_o), 16'h1A);

`ifdef STARFORC_GFXARB_DL_EN
    begin
      int  acks;
      bit  seen_wr;
      acks    = 0;
      seen_wr = 1'b0;
      chr_addr = 12'h020;
      wait_rd("dl_chr_rise", 1'b1);
      chk("dl_chr_a0", mif.mem_addr, 16'h0020);
      dl_addr = 16'h4000;
      dl_data = 8'hA5;
      dl_wr   = 1'b1;
      for (int c = 0; c < 60; c++) begin
        tick(1);
        if (mif.mem_wr === 1'b1 && !seen_wr) begin
          seen_wr = 1'b1;
          chk("dl_after_commit", 16'(chr_valid), 16'h1);
          chk("dl_no_rd", 16'(mif.mem_rd), 16'h0);
          chk("dl_addr", mif.mem_addr, 16'h4000);
        end
        if (dl_ack === 1'b1) begin
          acks++;
          dl_wr = 1'b0;
        end
      end
      chk("dl_wr_seen", 16'(seen_wr), 16'h1);
      chk("dl_ack_count", 16'(acks), 16'h1);
      tick(60);
      chk("dl_rom9", 16'(rom9_o), 16'hA5);
      chk("dl_spr_valid", 16'(spr_valid), 16'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
